rx_line_checker: RTL and testbench
==================================

RX_LINE_CHECKER -- requirements
Module: rx_line_checker

Interface
REQ-001 SHALL have parameter MAX_LEN, default 16, line-buffer depth in bytes; legal range 13..31.
REQ-002 SHALL have parameter EXP_LEN, default 13, length of the fixed expected message "HELLO WORLD!\n" (72,69,76,76,79,32,87,79,82,76,68,33,10).
REQ-003 SHALL have port clock, input, 1: rising-edge clock for all state.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port RxFull, input, 1: UART receiver holds a byte; stays high until read.
REQ-006 SHALL have port RxData, input, 8: received byte, valid while RxFull=1.
REQ-007 SHALL have port RxRead, output, 1: one-cycle pop strobe to the receiver.
REQ-008 SHALL have ports MsgOk and MsgErr, outputs, 1 each: one-cycle verdict pulses.
REQ-009 SHALL have ports OkCount and ErrCount, outputs, 8 each: saturating verdict counters.
REQ-010 SHALL have port LastLen, output, 5: byte count of the last completed line, newline included.
REQ-011 SHALL have port Overflow, output, 1: the last completed line exceeded MAX_LEN.
REQ-012 SHALL have ports EchoData (output, 8) and EchoGo (output, 1): byte echo toward a transmitter.

Function
REQ-013 SHALL implement FSM states IDLE, ACK, CHECK, REPORT.
REQ-014 IDLE with RxFull=1: SHALL store RxData at wrPtr if wrPtr<MAX_LEN, otherwise set the overflow flag and discard the byte; SHALL increment lineLen (saturating at 31), register RxRead=1 for the next cycle, and go to ACK.
REQ-015 ACK: SHALL hold RxRead=0 after its single cycle and wait until RxFull=0, so one byte is never popped twice.
REQ-016 ACK exit with RxFull=0: if the stored or discarded byte was 10 (newline), SHALL go to CHECK with index=0; otherwise SHALL go to IDLE.
REQ-017 CHECK: SHALL compare one buffered byte per cycle against the expected byte at that index; the first mismatch, lineLen!=EXP_LEN, or the overflow flag SHALL mark the line bad and go to REPORT; otherwise it SHALL go to REPORT after index EXP_LEN-1.
REQ-018 Latency from the ACK exit of the newline to the verdict pulse SHALL be at most EXP_LEN+1 cycles.
REQ-019 REPORT: SHALL pulse exactly one of MsgOk or MsgErr for one cycle, increment the matching counter (saturating at 255), latch LastLen=lineLen and Overflow=flag, clear wrPtr, lineLen and flag, and return to IDLE.
REQ-020 SHALL not assert RxRead in CHECK or REPORT; a byte arriving then SHALL wait in the receiver as backpressure and SHALL not be lost.
REQ-021 A newline as the first byte SHALL produce an empty line: LastLen=1 and MsgErr.
REQ-022 Once wrPtr reaches MAX_LEN, later bytes SHALL still be popped and counted until a newline arrives; the line SHALL then be reported bad with Overflow=1.

Reset
REQ-023 On reset SHALL force state=IDLE; RxRead, MsgOk, MsgErr, EchoGo=0; OkCount, ErrCount, LastLen=0; Overflow=0; EchoData=0; wrPtr, lineLen, index and flag=0.
REQ-024 Reset in any state, including mid-line or mid-CHECK, SHALL discard the partial line and emit no verdict pulse.
REQ-025 Reset SHALL take priority over every other event in the same cycle.

Configuration
REQ-026 With macro RX_ECHO_EN defined: in the cycle RxRead=1, SHALL drive EchoGo=1 for one cycle with EchoData set to that byte; EchoData SHALL hold that byte until the next echo.
REQ-027 Without RX_ECHO_EN: EchoGo and EchoData SHALL be constant 0 and no echo logic SHALL be synthesized; ports SHALL remain present.

Verification
REQ-028 Reset, then feed "HELLO WORLD!\n" one byte per RxFull handshake -> 13 RxRead pulses, one MsgOk, OkCount=1, LastLen=13, Overflow=0.
REQ-029 Feed "HELLO WORLE!\n" -> MsgErr pulse, ErrCount=1, LastLen=13.
REQ-030 Feed 20 bytes of 65 then 10 -> 21 RxRead pulses, MsgErr, Overflow=1, LastLen=21.
REQ-031 Hold RxFull=1 with the next byte during CHECK -> RxRead stays 0 until REPORT completes, then the byte is read in IDLE.
REQ-032 Assert reset after 5 bytes, then send a correct line -> no verdict for the partial line, MsgOk for the new line, OkCount=1.
REQ-033 With RX_ECHO_EN defined, send "HI\n" -> three EchoGo pulses carrying 72, 73, 10; without the macro -> EchoGo stays 0.

Source files
------------

// File: rtl/rx_line_checker.sv
// Line checker: buffers UART bytes up to newline, compares to "HELLO WORLD!\n".
// Ports: clock/reset, RxFull/RxData/RxRead (receiver handshake), MsgOk/MsgErr
// verdict pulses, OkCount/ErrCount, LastLen, Overflow, EchoData/EchoGo.
// Optional byte echo enabled by defining RX_ECHO_EN.
module rx_line_checker #(
    parameter int MAX_LEN = 16,
    parameter int EXP_LEN = 13
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       RxFull,
    input  logic [7:0] RxData,
    output logic       RxRead,
    output logic       MsgOk,
    output logic       MsgErr,
    output logic [7:0] OkCount,
    output logic [7:0] ErrCount,
    output logic [4:0] LastLen,
    output logic       Overflow,
    output logic [7:0] EchoData,
    output logic       EchoGo
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACK    = 2'd1;
    localparam logic [1:0] CHECK  = 2'd2;
    localparam logic [1:0] REPORT = 2'd3;

    localparam int AW = $clog2(MAX_LEN);
    localparam logic [4:0] MAXP = 5'(MAX_LEN);
    localparam logic [4:0] ELEN = 5'(EXP_LEN);
    localparam logic [4:0] ELAST = 5'(EXP_LEN - 1);

    logic [1:0] state;
    logic [4:0] wrPtr;
    logic [4:0] lineLen;
    logic [4:0] index;
    logic       flag;
    logic       isNl;
    logic       bad;
    logic       miss;
    logic [7:0] lineBuf [MAX_LEN];

    function automatic logic [7:0] exp_byte(input logic [4:0] i);
        logic [7:0] b;
        case (i)
            5'd0:    b = 8'd72;
            5'd1:    b = 8'd69;
            5'd2:    b = 8'd76;
            5'd3:    b = 8'd76;
            5'd4:    b = 8'd79;
            5'd5:    b = 8'd32;
            5'd6:    b = 8'd87;
            5'd7:    b = 8'd79;
            5'd8:    b = 8'd82;
            5'd9:    b = 8'd76;
            5'd10:   b = 8'd68;
            5'd11:   b = 8'd33;
            5'd12:   b = 8'd10;
            default: b = 8'd0;
        endcase
        return b;
    endfunction

    // Any of these makes the line bad; checked every CHECK cycle.
    assign miss = flag || (lineLen != ELEN) ||
                  (lineBuf[index[AW-1:0]] != exp_byte(index));

    always_ff @(posedge clock) begin
        if (state == IDLE && RxFull && wrPtr < MAXP)
            lineBuf[wrPtr[AW-1:0]] <= RxData;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            RxRead   <= 1'b0;
            MsgOk    <= 1'b0;
            MsgErr   <= 1'b0;
            OkCount  <= 8'd0;
            ErrCount <= 8'd0;
            LastLen  <= 5'd0;
            Overflow <= 1'b0;
            wrPtr    <= 5'd0;
            lineLen  <= 5'd0;
            index    <= 5'd0;
            flag     <= 1'b0;
            isNl     <= 1'b0;
            bad      <= 1'b0;
        end else begin
            RxRead <= 1'b0;
            MsgOk  <= 1'b0;
            MsgErr <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (RxFull) begin
                        if (wrPtr < MAXP)
                            wrPtr <= wrPtr + 5'd1;
                        else
                            flag <= 1'b1;
                        if (lineLen != 5'd31)
                            lineLen <= lineLen + 5'd1;
                        isNl   <= (RxData == 8'd10);
                        RxRead <= 1'b1;
                        state  <= ACK;
                    end
                end
                // Wait for the receiver to drop RxFull before the next pop.
                ACK: begin
                    if (!RxFull) begin
                        if (isNl) begin
                            index <= 5'd0;
                            state <= CHECK;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                CHECK: begin
                    if (miss) begin
                        bad   <= 1'b1;
                        state <= REPORT;
                    end else if (index == ELAST) begin
                        bad   <= 1'b0;
                        state <= REPORT;
                    end else begin
                        index <= index + 5'd1;
                    end
                end
                REPORT: begin
                    MsgOk  <= !bad;
                    MsgErr <= bad;
                    if (!bad && OkCount != 8'd255)
                        OkCount <= OkCount + 8'd1;
                    if (bad && ErrCount != 8'd255)
                        ErrCount <= ErrCount + 8'd1;
                    LastLen  <= lineLen;
                    Overflow <= flag;
                    wrPtr    <= 5'd0;
                    lineLen  <= 5'd0;
                    flag     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef RX_ECHO_EN
    // Echo fires on the same edge that raises RxRead.
    always_ff @(posedge clock) begin
        if (reset) begin
            EchoGo   <= 1'b0;
            EchoData <= 8'd0;
        end else begin
            EchoGo <= 1'b0;
            if (state == IDLE && RxFull) begin
                EchoGo   <= 1'b1;
                EchoData <= RxData;
            end
        end
    end
`else
    assign EchoGo   = 1'b0;
    assign EchoData = 8'd0;
`endif

endmodule

// File: tb/tb_rx_line_checker.sv
// Self-checking bench for rx_line_checker: directed lines plus random lines
// compared against a whole-line reference model.
module tb_rx_line_checker;

    localparam int MAX_LEN = 16;
    localparam int EXP_LEN = 13;

    logic       clock = 1'b0;
    logic       reset;
    logic       RxFull;
    logic [7:0] RxData;
    logic       RxRead;
    logic       MsgOk;
    logic       MsgErr;
    logic [7:0] OkCount;
    logic [7:0] ErrCount;
    logic [4:0] LastLen;
    logic       Overflow;
    logic [7:0] EchoData;
    logic       EchoGo;

    always #5 clock = ~clock;

    rx_line_checker #(.MAX_LEN(MAX_LEN), .EXP_LEN(EXP_LEN)) dut (
        .clock(clock), .reset(reset), .RxFull(RxFull), .RxData(RxData),
        .RxRead(RxRead), .MsgOk(MsgOk), .MsgErr(MsgErr),
        .OkCount(OkCount), .ErrCount(ErrCount), .LastLen(LastLen),
        .Overflow(Overflow), .EchoData(EchoData), .EchoGo(EchoGo)
    );

    int errors = 0;
    int checks = 0;
    int nRead = 0, nOk = 0, nErr = 0, nEcho = 0;
    logic [7:0] echoQ[$];
    int expOk = 0, expErr = 0;
    logic [7:0] msg [13] = '{8'd72, 8'd69, 8'd76, 8'd76, 8'd79, 8'd32,
                             8'd87, 8'd79, 8'd82, 8'd76, 8'd68, 8'd33,
                             8'd10};

    always @(negedge clock) begin
        if (RxRead === 1'b1) nRead++;
        if (MsgOk === 1'b1) nOk++;
        if (MsgErr === 1'b1) nErr++;
        if (EchoGo === 1'b1) begin
            nEcho++;
            echoQ.push_back(EchoData);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clock);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        RxFull = 1'b0;
        RxData = 8'd0;
        tick;
        tick;
        expOk = 0;
        expErr = 0;
        check("rst_rxread", RxRead, 0);
        check("rst_msgok", MsgOk, 0);
        check("rst_msgerr", MsgErr, 0);
        check("rst_okcount", OkCount, 0);
        check("rst_errcount", ErrCount, 0);
        check("rst_lastlen", LastLen, 0);
        check("rst_overflow", Overflow, 0);
        check("rst_echogo", EchoGo, 0);
        check("rst_echodata", EchoData, 0);
        reset = 1'b0;
        tick;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        RxData = b;
        RxFull = 1'b1;
        while (RxRead !== 1'b1 && n < 60) begin
            tick;
            n++;
        end
        if (n >= 60) check("rxread_timeout", 0, 1);
        RxFull = 1'b0;
        tick;
    endtask

    task automatic send_line(input logic [7:0] q[$]);
        foreach (q[i]) send_byte(q[i]);
    endtask

    task automatic wait_verdict(output bit got);
        int n0 = nOk + nErr;
        int n = 0;
        while (nOk + nErr == n0 && n < 40) begin
            tick;
            n++;
        end
        got = (nOk + nErr != n0);
    endtask

    // Reference: a line is good only if it is exactly the expected message.
    task automatic run_line(input string tag, input logic [7:0] q[$]);
        bit good, got;
        int len, r0, o0, e0;
        good = (q.size() == 13);
        foreach (q[i]) if (i >= 13 || q[i] !== msg[i]) good = 0;
        len = (q.size() > 31) ? 31 : q.size();
        r0 = nRead; o0 = nOk; e0 = nErr;
        send_line(q);
        wait_verdict(got);
        tick;
        tick;
        if (good) expOk = (expOk < 255) ? expOk + 1 : 255;
        else expErr = (expErr < 255) ? expErr + 1 : 255;
        check({tag, "_verdict"}, got, 1);
        check({tag, "_reads"}, nRead - r0, q.size());
        check({tag, "_okpulse"}, nOk - o0, good ? 1 : 0);
        check({tag, "_errpulse"}, nErr - e0, good ? 0 : 1);
        check({tag, "_okcount"}, OkCount, expOk);
        check({tag, "_errcount"}, ErrCount, expErr);
        check({tag, "_lastlen"}, LastLen, len);
        check({tag, "_overflow"}, Overflow, (q.size() > MAX_LEN) ? 1 : 0);
    endtask

    initial begin
        logic [7:0] q[$];
        bit got;
        int r0, o0, e0;
        do_reset;

        q = {};
        foreach (msg[i]) q.push_back(msg[i]);
        run_line("good", q);

        q[10] = 8'd69;
        run_line("bad", q);

        q = {};
        for (int i = 0; i < 20; i++) q.push_back(8'd65);
        q.push_back(8'd10);
        run_line("ovf", q);

        q = '{8'd10};
        run_line("empty", q);

        q = {};
        foreach (msg[i]) q.push_back(msg[i]);
        o0 = nOk;
        send_line(q);
        RxData = 8'd72;
        RxFull = 1'b1;
        r0 = nRead;
        wait_verdict(got);
        expOk++;
        check("bp_verdict", got, 1);
        check("bp_noread", nRead - r0, 0);
        check("bp_okpulse", nOk - o0, 1);
        check("bp_okcount", OkCount, expOk);
        run_line("bp_next", q);

        for (int i = 0; i < 5; i++) send_byte(msg[i]);
        o0 = nOk; e0 = nErr;
        do_reset;
        for (int i = 0; i < 20; i++) tick;
        check("midrst_nook", nOk - o0, 0);
        check("midrst_noerr", nErr - e0, 0);
        run_line("after_rst", q);

        e0 = echoQ.size();
        r0 = nEcho;
        q = '{8'd72, 8'd73, 8'd10};
        run_line("hi", q);
`ifdef RX_ECHO_EN
        check("echo_count", nEcho - r0, 3);
        for (int i = 0; i < 3; i++)
            if (e0 + i < echoQ.size())
                check("echo_byte", echoQ[e0 + i], q[i]);
        check("echo_hold", EchoData, 8'd10);
`else
        check("echo_count", nEcho - r0, 0);
        check("echo_data", EchoData, 0);
`endif

        for (int k = 0; k < 12; k++) begin
            int kind, n, p;
            kind = $urandom_range(0, 3);
            q = {};
            if (kind <= 1) begin
                foreach (msg[i]) q.push_back(msg[i]);
                if (kind == 1) begin
                    p = $urandom_range(0, 11);
                    q[p] = msg[p] ^ {1'b1, 7'($urandom)};
                end
            end else if (kind == 2) begin
                n = $urandom_range(0, 34);
                for (int i = 0; i < n; i++) begin
                    logic [7:0] b;
                    b = 8'($urandom);
                    if (b == 8'd10) b = 8'd11;
                    q.push_back(b);
                end
                q.push_back(8'd10);
            end else begin
                n = $urandom_range(0, 12);
                for (int i = 0; i < n; i++) q.push_back(msg[i]);
                q.push_back(8'd10);
            end
            run_line("rand", q);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
